tcp_tmp_rx_buf_reader: RTL and testbench

//  Read side of the RX temporary payload buffer. Takes one payload_buf_struct entry
//  (slab addr + payload len) and reads its lines out of the tmp-buffer memory.

---
 rtl/tcp_pkg.sv | 28 ++
 rtl/tcp_tmp_rx_buf_reader_fifo.sv | 84 ++++++++
 rtl/tcp_tmp_rx_buf_reader.sv | 194 +++++++++++++++++++
 tb/tb_tcp_tmp_rx_buf_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// ============================================================================
//  Module      : tcp_pkg
//  Description : Shared TCP datapath types and widths used by the RX
//                temporary payload buffer and its reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tcp_pkg;

    // Width of one MAC-side line / flit in bits
    localparam int MAC_INTERFACE_W       = 512;
    // Byte address width of the RX temporary payload buffer
    localparam int RX_TMP_BUF_ADDR_W     = 14;
    // Line address width of the RX temporary payload buffer memory
    localparam int RX_TMP_BUF_MEM_ADDR_W = RX_TMP_BUF_ADDR_W - $clog2(MAC_INTERFACE_W / 8);
    // Width of a TCP total-length field
    localparam int TOT_LEN_W             = 16;

    // One buffered payload: slab start address and payload length in bytes
    typedef struct packed {
        logic [RX_TMP_BUF_ADDR_W-1:0] payload_addr;
        logic [TOT_LEN_W-1:0]         payload_len;
    } payload_buf_struct;

endpackage

`default_nettype wire

// File: rtl/tcp_tmp_rx_buf_reader_fifo.sv
// ============================================================================
//  Module      : tcp_tmp_rx_buf_reader_fifo
//  Description : Two-entry registered FIFO holding {data, last, padbytes}
//                flits between the tmp-buffer memory and the downstream
//                consumer. Exposes its occupancy so the reader can throttle
//                read requests.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcp_tmp_rx_buf_reader_fifo #(
    parameter int DATA_W = 512,
    parameter int PAD_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_push_last,
    input  logic [PAD_W-1:0]  i_push_pad,
    input  logic              i_pop,
    output logic              o_val,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [PAD_W-1:0]  o_pad,
    output logic [1:0]        o_count
);

    localparam int C_ENTRY_W = DATA_W + 1 + PAD_W;

    logic [C_ENTRY_W-1:0] r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic                 w_pop;
    logic [C_ENTRY_W-1:0] w_head;

    // A pop with nothing stored is ignored so the pointers can never skew
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign w_head  = r_mem[r_rd_ptr];
    assign o_val   = (r_count != 2'd0);
    assign o_data  = w_head[C_ENTRY_W-1 -: DATA_W];
    assign o_last  = w_head[PAD_W];
    assign o_pad   = w_head[PAD_W-1:0];
    assign o_count = r_count;

    // Storage write: data registers carry no reset
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= {i_push_data, i_push_last, i_push_pad};
        end
    end

    // Pointer and occupancy tracking; push and pop together keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Writing into a full FIFO without a simultaneous pop would lose a line
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && !w_pop && (r_count == 2'd2)));
        end
    end

endmodule

`default_nettype wire

// File: rtl/tcp_tmp_rx_buf_reader.sv
// ============================================================================
//  Module      : tcp_tmp_rx_buf_reader
//  Description : Read side of the RX temporary payload buffer. Accepts one
//                {slab addr, payload len} entry, reads its lines from the
//                tmp-buffer memory, streams them downstream with last and
//                padbytes, then returns the slab to the allocator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcp_tmp_rx_buf_reader
    import tcp_pkg::*;
#(
    parameter  int DATA_W     = MAC_INTERFACE_W,
    parameter  int ADDR_W     = RX_TMP_BUF_ADDR_W,
    parameter  int MEM_ADDR_W = RX_TMP_BUF_MEM_ADDR_W,
    parameter  int LEN_W      = TOT_LEN_W,
    localparam int BYTES      = DATA_W / 8,
    localparam int BYTES_W    = $clog2(BYTES)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  src_reader_req_val,
    input  payload_buf_struct     src_reader_req_entry,
    output logic                  src_reader_req_rdy,

    output logic                  reader_mem_rd_req_val,
    output logic [MEM_ADDR_W-1:0] reader_mem_rd_req_addr,
    input  logic                  mem_reader_rd_req_rdy,

    input  logic                  mem_reader_rd_resp_val,
    input  logic [DATA_W-1:0]     mem_reader_rd_resp_data,

    output logic                  reader_dst_data_val,
    output logic [DATA_W-1:0]     reader_dst_data,
    output logic                  reader_dst_data_last,
    output logic [BYTES_W-1:0]    reader_dst_data_padbytes,
    input  logic                  dst_reader_data_rdy,

    output logic                  reader_free_slab_req_val,
    output logic [ADDR_W-1:0]     reader_free_slab_req_addr,
    input  logic                  free_slab_reader_req_rdy
);

    // Enough bits to hold ceil(2^LEN_W-1 / BYTES)
    localparam int C_LINES_W = LEN_W - BYTES_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FREE  = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;

    logic [ADDR_W-1:0]     r_addr;
    logic [BYTES_W-1:0]    r_pad;
    logic [C_LINES_W-1:0]  r_lines;
    logic [C_LINES_W-1:0]  r_issued;
    logic [C_LINES_W-1:0]  r_recv;
    logic [MEM_ADDR_W-1:0] r_rd_ptr;
    logic                  r_inflight;

    logic                  w_accept;
    logic                  w_rd_fire;
    logic                  w_pop;
    logic [1:0]            w_fifo_count;
    logic [2:0]            w_occ;
    logic [C_LINES_W-1:0]  w_lines_new;
    logic                  w_push_last;
    logic [BYTES_W-1:0]    w_push_pad;

    assign w_accept  = src_reader_req_val && src_reader_req_rdy;
    assign w_rd_fire = reader_mem_rd_req_val && mem_reader_rd_req_rdy;
    assign w_pop     = reader_dst_data_val && dst_reader_data_rdy;

    // Lines owed to the FIFO next cycle: stored + in flight, less what leaves now
    assign w_occ = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_lines_new = C_LINES_W'((32'(src_reader_req_entry.payload_len) + 32'(BYTES - 1)) >> BYTES_W);

    // Tag each arriving line: the final one carries the trailing pad count
    assign w_push_last = (r_recv == (r_lines - C_LINES_W'(1)));
    assign w_push_pad  = w_push_last ? r_pad : '0;

    assign reader_mem_rd_req_addr    = r_rd_ptr;
    assign reader_free_slab_req_addr = r_addr;

    tcp_tmp_rx_buf_reader_fifo #(
        .DATA_W (DATA_W),
        .PAD_W  (BYTES_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (mem_reader_rd_resp_val),
        .i_push_data (mem_reader_rd_resp_data),
        .i_push_last (w_push_last),
        .i_push_pad  (w_push_pad),
        .i_pop       (w_pop),
        .o_val       (reader_dst_data_val),
        .o_data      (reader_dst_data),
        .o_last      (reader_dst_data_last),
        .o_pad       (reader_dst_data_padbytes),
        .o_count     (w_fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt              = r_state;
        src_reader_req_rdy       = 1'b0;
        reader_mem_rd_req_val    = 1'b0;
        reader_free_slab_req_val = 1'b0;
        case (r_state)
            S_IDLE: begin
                src_reader_req_rdy = 1'b1;
                if (w_accept) begin
                    w_state_nxt = (src_reader_req_entry.payload_len == '0) ? S_FREE : S_READ;
                end
            end
            S_READ: begin
                reader_mem_rd_req_val = (r_issued < r_lines) && (w_occ < 3'd2);
                if (w_rd_fire && (r_issued == (r_lines - C_LINES_W'(1)))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_inflight && (w_fifo_count == 2'd0)) begin
                    w_state_nxt = S_FREE;
                end
            end
            S_FREE: begin
                reader_free_slab_req_val = 1'b1;
                if (free_slab_reader_req_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Entry latch, read pointer and line counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_pad      <= '0;
            r_lines    <= '0;
            r_issued   <= '0;
            r_recv     <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_fire;
            if (w_accept) begin
                r_addr   <= src_reader_req_entry.payload_addr;
                r_pad    <= BYTES_W'(BYTES - int'(src_reader_req_entry.payload_len[BYTES_W-1:0]));
                r_lines  <= w_lines_new;
                r_issued <= '0;
                r_recv   <= '0;
                // Slabs are line aligned, so the low byte-offset bits are dropped
                r_rd_ptr <= src_reader_req_entry.payload_addr[ADDR_W-1:BYTES_W];
            end else begin
                if (w_rd_fire) begin
                    r_issued <= r_issued + C_LINES_W'(1);
                    r_rd_ptr <= r_rd_ptr + MEM_ADDR_W'(1);
                end
                if (mem_reader_rd_resp_val) begin
                    r_recv <= r_recv + C_LINES_W'(1);
                end
            end
        end
    end

    // A response must always correspond to a read accepted the cycle before
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_reader_rd_resp_val && !r_inflight));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tcp_tmp_rx_buf_reader.sv
// ============================================================================
//  Module      : tb_tcp_tmp_rx_buf_reader
//  Description : Scoreboard bench for the RX tmp-buffer reader. Directed
//                entries push hand-computed read addresses, flits and free
//                addresses into queues; a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tcp_tmp_rx_buf_reader;
    import tcp_pkg::*;

    localparam int DATA_W     = MAC_INTERFACE_W;
    localparam int BYTES_W    = 6;
    localparam int ADDR_W     = RX_TMP_BUF_ADDR_W;
    localparam int MEM_ADDR_W = RX_TMP_BUF_MEM_ADDR_W;

    typedef struct {
        logic [MEM_ADDR_W-1:0] line;
        logic                  last;
        logic [BYTES_W-1:0]    pad;
    } flit_t;

    logic                  clk;
    logic                  rst;
    logic                  req_val;
    payload_buf_struct     req_entry;
    logic                  req_rdy;
    logic                  rd_val;
    logic [MEM_ADDR_W-1:0] rd_addr;
    logic                  mem_rdy;
    logic                  resp_val;
    logic [DATA_W-1:0]     resp_data;
    logic                  dst_val;
    logic [DATA_W-1:0]     dst_data;
    logic                  dst_last;
    logic [BYTES_W-1:0]    dst_pad;
    logic                  dst_rdy;
    logic                  free_val;
    logic [ADDR_W-1:0]     free_addr;
    logic                  free_rdy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_rd_acc = 0;
    int n_free   = 0;
    int outstanding = 0;
    int max_out  = 0;
    int acc_cyc  = 0;
    int free_cyc = 0;
    int q_rd_cyc [$];
    logic [MEM_ADDR_W-1:0] exp_rd [$];
    flit_t                 exp_fl [$];
    logic [ADDR_W-1:0]     exp_free [$];
    logic                  tog = 1'b0;

    tcp_tmp_rx_buf_reader dut (
        .clk                       (clk),
        .rst                       (rst),
        .src_reader_req_val        (req_val),
        .src_reader_req_entry      (req_entry),
        .src_reader_req_rdy        (req_rdy),
        .reader_mem_rd_req_val     (rd_val),
        .reader_mem_rd_req_addr    (rd_addr),
        .mem_reader_rd_req_rdy     (mem_rdy),
        .mem_reader_rd_resp_val    (resp_val),
        .mem_reader_rd_resp_data   (resp_data),
        .reader_dst_data_val       (dst_val),
        .reader_dst_data           (dst_data),
        .reader_dst_data_last      (dst_last),
        .reader_dst_data_padbytes  (dst_pad),
        .dst_reader_data_rdy       (dst_rdy),
        .reader_free_slab_req_val  (free_val),
        .reader_free_slab_req_addr (free_addr),
        .free_slab_reader_req_rdy  (free_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: every line tagged with its own address
    function automatic logic [DATA_W-1:0] line_data(input logic [MEM_ADDR_W-1:0] l);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) begin
            d[32*i +: 32] = {8'hD0, 8'(i), 8'h5A, 8'(l)};
        end
        return d;
    endfunction

    // Memory model: one-cycle read latency
    always @(posedge clk) begin
        if (rst) begin
            resp_val <= 1'b0;
        end else begin
            resp_val  <= rd_val & mem_rdy;
            resp_data <= line_data(rd_addr);
        end
    end

    task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_val && mem_rdy) begin
                n_rd_acc++;
                outstanding++;
                q_rd_cyc.push_back(cyc);
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got read at line %0h, expected none", rd_addr);
                end else begin
                    chk("rd_addr", 528'(rd_addr), 528'(exp_rd.pop_front()));
                end
            end
            if (dst_val && dst_rdy) begin
                outstanding--;
                if (exp_fl.size() == 0) begin
                    n_checks++;
                    $display("FAIL flit_unexpected: got flit last=%0b pad=%0d, expected none", dst_last, dst_pad);
                end else begin
                    flit_t e;
                    e = exp_fl.pop_front();
                    chk("flit", {dst_data, dst_last, dst_pad}, {line_data(e.line), e.last, e.pad});
                end
            end
            if (outstanding > max_out) max_out = outstanding;
            if (free_val && free_rdy) begin
                n_free++;
                free_cyc = cyc;
                if (exp_free.size() == 0) begin
                    n_checks++;
                    $display("FAIL free_unexpected: got free %0h, expected none", free_addr);
                end else begin
                    chk("free_addr", 528'(free_addr), 528'(exp_free.pop_front()));
                end
            end
        end
    end

    task automatic expect_xfer(input logic [MEM_ADDR_W-1:0] first, input int n,
                               input logic [BYTES_W-1:0] pad, input logic [ADDR_W-1:0] fa);
        logic [MEM_ADDR_W-1:0] ln;
        for (int i = 0; i < n; i++) begin
            ln = first + MEM_ADDR_W'(i);
            exp_rd.push_back(ln);
            exp_fl.push_back('{line: ln, last: (i == n - 1), pad: (i == n - 1) ? pad : '0});
        end
        exp_free.push_back(fa);
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [15:0] l);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_rdy) begin
            n_checks++;
            $display("FAIL send_timeout: req_rdy got 0, expected 1");
        end
        req_val   = 1'b1;
        req_entry = '{payload_addr: a, payload_len: l};
        @(posedge clk);
        acc_cyc = cyc;
        #1 req_val = 1'b0;
    endtask

    task automatic wait_free(input int target);
        int t;
        t = 0;
        while (n_free < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (n_free < target) begin
            n_checks++;
            $display("FAIL free_timeout: got %0d frees, expected %0d", n_free, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        rst = 1'b1; req_val = 1'b0; req_entry = '0;
        mem_rdy = 1'b1; dst_rdy = 1'b1; free_rdy = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_val",   528'(rd_val),   528'(0));
        chk("rst_dst_val",  528'(dst_val),  528'(0));
        chk("rst_free_val", 528'(free_val), 528'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy",  528'(req_rdy),  528'(1));

        // 1: two lines, second padded by 28 bytes
        q_rd_cyc.delete();
        max_out = 0;
        expect_xfer(8'h10, 2, 6'd28, 14'h0400);
        send(14'h0400, 16'd100);
        wait_free(1);
        chk("t1_nreads",     528'(q_rd_cyc.size()), 528'(2));
        chk("t1_first_lat",  528'(q_rd_cyc[0] - acc_cyc), 528'(1));
        chk("t1_consec",     528'(q_rd_cyc[1] - q_rd_cyc[0]), 528'(1));

        // 2a: exactly one line
        expect_xfer(8'h20, 1, 6'd0, 14'h0800);
        send(14'h0800, 16'd64);
        wait_free(2);

        // 2b: zero-length payload frees the slab without touching memory
        q_rd_cyc.delete();
        exp_free.push_back(14'h0C00);
        send(14'h0C00, 16'd0);
        wait_free(3);
        chk("t2_len0_reads", 528'(q_rd_cyc.size()), 528'(0));
        chk("t2_len0_lat",   528'((free_cyc - acc_cyc) <= 2), 528'(1));

        // 3: five lines with downstream back-pressure every other cycle
        max_out = 0;
        tog = 1'b1;
        fork
            begin
                while (tog) begin
                    @(negedge clk);
                    if (tog) dst_rdy = ~dst_rdy;
                end
            end
        join_none
        expect_xfer(8'h40, 5, 6'd20, 14'h1000);
        send(14'h1000, 16'd300);
        wait_free(4);
        tog = 1'b0;
        @(negedge clk);
        dst_rdy = 1'b1;
        chk("t3_max_outstanding", 528'(max_out <= 2), 528'(1));

        // 4: memory stalls for five cycles after the first read
        expect_xfer(8'h50, 4, 6'd0, 14'h1400);
        send(14'h1400, 16'd256);
        @(posedge clk);
        #1 mem_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_val",  528'(rd_val),  528'(1));
            chk("t4_stall_addr", 528'(rd_addr), 528'(8'h51));
        end
        mem_rdy = 1'b1;
        wait_free(5);

        // 5: line address wraps from the top of memory to line 0
        expect_xfer(8'hFF, 2, 6'd0, 14'h3FC0);
        send(14'h3FC0, 16'd128);
        wait_free(6);

        // 6: reset while draining, then a normal transfer
        dst_rdy = 1'b0;
        base = n_rd_acc;
        exp_rd.push_back(8'h60);
        exp_rd.push_back(8'h61);
        send(14'h1800, 16'd128);
        t = 0;
        while (n_rd_acc < base + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t6_reads_before_rst", 528'(n_rd_acc - base), 528'(2));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_rd_val",   528'(rd_val),   528'(0));
        chk("t6_rst_dst_val",  528'(dst_val),  528'(0));
        chk("t6_rst_free_val", 528'(free_val), 528'(0));
        chk("t6_rst_req_rdy",  528'(req_rdy),  528'(1));
        rst = 1'b0;
        dst_rdy = 1'b1;
        outstanding = 0;
        expect_xfer(8'h70, 1, 6'd0, 14'h1C00);
        send(14'h1C00, 16'd64);
        wait_free(7);

        repeat (3) @(negedge clk);
        chk("end_exp_rd_empty",   528'(exp_rd.size()),   528'(0));
        chk("end_exp_fl_empty",   528'(exp_fl.size()),   528'(0));
        chk("end_exp_free_empty", 528'(exp_free.size()), 528'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
